axis_pattern_gen: RTL and testbench



---
 rtl/axis_pattern_gen.sv | 176 +++++++++++++++++
 tb/tb_axis_pattern_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_gen.sv
// axis_pattern_gen: AXI4-Stream RGB test-pattern source (bars, gradient, checkerboard, solid).
// Optional horizontal scrolling of gradient/checkerboard when AXIS_PATTERN_SCROLL_EN is defined.
`default_nettype none

module axis_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [23:0] solid_rgb,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tlast,
   output logic [7:0]  frame_count
);

   localparam int          BAR_W  = H_ACTIVE / 8;
   localparam int          BC_W   = $clog2(BAR_W + 1);
   localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
   localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BAR_W - 1);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t            state, state_nx;
   logic [10:0]       x, y, x_nx, y_nx;
   logic [2:0]        bar, bar_nx;
   logic [BC_W-1:0]   bar_cnt, bar_cnt_nx;
   logic [1:0]        sel_q, sel_eff;
   logic [23:0]       rgb_q, rgb_eff, pix;
   logic [7:0]        xe;
   logic              start, adv, stop;
   logic              hs, last_hs;

   assign hs      = m_axis_tvalid & m_axis_tready;
   assign last_hs = hs & m_axis_tlast;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // x/y/bar always describe the pixel that sits in the output register.
   always_comb begin
      state_nx   = state;
      start      = 1'b0;
      adv        = 1'b0;
      stop       = 1'b0;
      x_nx       = x;
      y_nx       = y;
      bar_nx     = bar;
      bar_cnt_nx = bar_cnt;
      case (state)
         S_IDLE: begin
            if (enable) begin
               start    = 1'b1;
               state_nx = S_RUN;
            end
         end
         S_RUN: begin
            if (last_hs) begin
               if (enable) begin
                  start = 1'b1;
               end else begin
                  stop     = 1'b1;
                  state_nx = S_IDLE;
               end
            end else if (hs) begin
               adv = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      if (start || stop) begin
         x_nx       = '0;
         y_nx       = '0;
         bar_nx     = '0;
         bar_cnt_nx = '0;
      end else if (adv) begin
         if (x == X_LAST) begin
            x_nx       = '0;
            y_nx       = y + 11'd1;
            bar_nx     = '0;
            bar_cnt_nx = '0;
         end else begin
            x_nx = x + 11'd1;
            if (bar_cnt == BC_LAST) begin
               bar_cnt_nx = '0;
               bar_nx     = bar + 3'd1;
            end else begin
               bar_cnt_nx = bar_cnt + 1'b1;
            end
         end
      end
   end

   // A new frame uses the live selections; otherwise the latched ones.
   assign sel_eff = start ? pattern_sel : sel_q;
   assign rgb_eff = start ? solid_rgb   : rgb_q;

`ifdef AXIS_PATTERN_SCROLL_EN
   logic [10:0] offset, offset_nx;
   assign offset_nx = last_hs ? offset + 11'd1 : offset;
   assign xe        = x_nx[7:0] + offset_nx[7:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) offset <= '0;
      else     offset <= offset_nx;
   end
`else
   assign xe = x_nx[7:0];
`endif

   always_comb begin
      pix = 24'h000000;
      case (sel_eff)
         2'd0: begin
            case (bar_nx)
               3'd0:    pix = 24'hFFFFFF;
               3'd1:    pix = 24'hFFFF00;
               3'd2:    pix = 24'h00FFFF;
               3'd3:    pix = 24'h00FF00;
               3'd4:    pix = 24'hFF00FF;
               3'd5:    pix = 24'hFF0000;
               3'd6:    pix = 24'h0000FF;
               default: pix = 24'h000000;
            endcase
         end
         2'd1:    pix = {xe, xe, xe};
         2'd2:    pix = (xe[3] ^ y_nx[3]) ? 24'hFFFFFF : 24'h000000;
         default: pix = rgb_eff;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x             <= '0;
         y             <= '0;
         bar           <= '0;
         bar_cnt       <= '0;
         sel_q         <= '0;
         rgb_q         <= '0;
         frame_count   <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         x       <= x_nx;
         y       <= y_nx;
         bar     <= bar_nx;
         bar_cnt <= bar_cnt_nx;
         if (start) begin
            sel_q <= pattern_sel;
            rgb_q <= solid_rgb;
         end
         if (last_hs) frame_count <= frame_count + 8'd1;
         if (start || adv) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {8'h00, pix};
            m_axis_tlast  <= (x_nx == X_LAST) && (y_nx == Y_LAST);
         end else if (stop) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_axis_pattern_gen.sv
// tb_axis_pattern_gen: randomized self-checking bench for axis_pattern_gen (16x4 frames).
`default_nettype none
`timescale 1ns/1ps

module tb_axis_pattern_gen;

   localparam int H = 16;
   localparam int V = 4;
   localparam int NPIX = H * V;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [1:0]  sel = 2'd0;
   logic [23:0] rgb = 24'h0;
   logic        tready = 1'b0;
   logic        tvalid, tlast;
   logic [31:0] tdata;
   logic [7:0]  fc;

   int n_tests = 0;
   int n_fail = 0;
   int mdl_frames = 0;
   int stab_err = 0;
   logic [31:0] beat_d[$];
   bit          beat_l[$];

   always #5 clk = ~clk;

   axis_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk(clk), .rst(rst), .enable(enable), .pattern_sel(sel), .solid_rgb(rgb),
      .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
      .m_axis_tlast(tlast), .frame_count(fc)
   );

   function automatic int cur_off();
`ifdef AXIS_PATTERN_SCROLL_EN
      return mdl_frames % 2048;
`else
      return 0;
`endif
   endfunction

   // Reference pixel straight from the pattern definitions.
   function automatic logic [31:0] exp_pix(input logic [1:0] s, input logic [23:0] c,
                                           input int x, input int y, input int off);
      int xe;
      logic [23:0] p;
      xe = (x + off) % 2048;
      case (s)
         2'd0: begin
            case (x / (H / 8))
               0: p = 24'hFFFFFF;  1: p = 24'hFFFF00;
               2: p = 24'h00FFFF;  3: p = 24'h00FF00;
               4: p = 24'hFF00FF;  5: p = 24'hFF0000;
               6: p = 24'h0000FF;  default: p = 24'h000000;
            endcase
         end
         2'd1: p = {3{8'(xe % 256)}};
         2'd2: p = (((xe / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
         default: p = c;
      endcase
      return {8'h00, p};
   endfunction

   // Drives tready and collects beats until the tlast handshake; called and returns at posedge+1.
   task automatic run_frame(input bit rnd, input int drop_at, input int chg_at,
                            input logic [1:0] chg_sel, output bit timeout);
      bit hs, stall;
      logic [31:0] pd;
      logic pl;
      logic [7:0] pfc;
      beat_d.delete();
      beat_l.delete();
      stab_err = 0;
      timeout = 1'b1;
      stall = 1'b0;
      pd = '0; pl = 1'b0; pfc = '0;
      for (int c = 0; c < 2000; c++) begin
         if (stall && (tvalid !== 1'b1 || tdata !== pd || tlast !== pl || fc !== pfc))
            stab_err++;
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = tvalid && tready;
         stall = tvalid && !tready;
         pd = tdata; pl = tlast; pfc = fc;
         if (hs) begin
            beat_d.push_back(tdata);
            beat_l.push_back(tlast);
         end
         @(posedge clk); #1;
         if (beat_d.size() == drop_at) enable = 1'b0;
         if (beat_d.size() == chg_at) sel = chg_sel;
         if (hs && pl) begin
            timeout = 1'b0;
            break;
         end
      end
      tready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'h0 || fc !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b l=%b d=%h fc=%0d, want 0/0/0/0", tvalid, tlast, tdata, fc);
      end
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: tvalid got %b want 0", tvalid);
      end
      mdl_frames = 0;
   endtask

   task automatic test_bars();
      bit to;
      int off, nl;
      sel = 2'd0; enable = 1'b1;
      off = cur_off();
      run_frame(1'b0, -1, -1, 2'd0, to);
      n_tests++;
      if (to || beat_d.size() != NPIX) begin
         n_fail++;
         $display("FAIL bars_beats: got %0d beats (timeout=%0d) want %0d", beat_d.size(), to, NPIX);
      end
      nl = 0;
      for (int k = 0; k < beat_d.size(); k++) begin
         n_tests++;
         if (beat_d[k] !== exp_pix(2'd0, rgb, k % H, k / H, off)) begin
            n_fail++;
            $display("FAIL bars_pix%0d: got %h want %h", k, beat_d[k], exp_pix(2'd0, rgb, k % H, k / H, off));
         end
         if (beat_l[k]) nl++;
      end
      if (beat_d.size() == NPIX) begin
         n_tests++;
         if (beat_d[0] !== 32'h00FFFFFF || beat_d[1] !== 32'h00FFFFFF || beat_d[2] !== 32'h00FFFF00 ||
             beat_d[3] !== 32'h00FFFF00 || beat_d[14] !== 32'h00000000 || beat_l[63] !== 1'b1 || nl != 1) begin
            n_fail++;
            $display("FAIL bars_spot: got %h %h %h %h %h lasts=%0d want 00ffffff x2 00ffff00 x2 0 lasts=1",
                     beat_d[0], beat_d[1], beat_d[2], beat_d[3], beat_d[14], nl);
         end
      end
      mdl_frames++;
      n_tests++;
      if (tvalid !== 1'b1 || tdata !== 32'h00FFFFFF || tlast !== 1'b0 || fc !== 8'd1) begin
         n_fail++;
         $display("FAIL bars_next_frame: got v=%b d=%h l=%b fc=%0d want 1/00ffffff/0/1", tvalid, tdata, tlast, fc);
      end
      enable = 1'b0;
      run_frame(1'b0, -1, -1, 2'd0, to);
      mdl_frames++;
      n_tests++;
      if (to || tvalid !== 1'b0 || fc !== 8'(mdl_frames)) begin
         n_fail++;
         $display("FAIL bars_drain: got v=%b fc=%0d to=%0d want v=0 fc=%0d", tvalid, fc, to, mdl_frames);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      int nl;
      sel = 2'd3; rgb = 24'h123456; enable = 1'b1;
      run_frame(1'b1, 5, -1, 2'd0, to);
      mdl_frames++;
      n_tests++;
      if (to || beat_d.size() != NPIX || stab_err != 0) begin
         n_fail++;
         $display("FAIL bp_frame: got %0d beats, %0d unstable cycles, to=%0d want %0d/0/0",
                  beat_d.size(), stab_err, to, NPIX);
      end
      nl = 0;
      for (int k = 0; k < beat_d.size(); k++) begin
         n_tests++;
         if (beat_d[k] !== 32'h00123456) begin
            n_fail++;
            $display("FAIL bp_pix%0d: got %h want 00123456", k, beat_d[k]);
         end
         if (beat_l[k]) nl++;
      end
      n_tests++;
      if (nl != 1 || fc !== 8'(mdl_frames) || tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_end: got lasts=%0d fc=%0d v=%b want 1/%0d/0", nl, fc, tvalid, mdl_frames);
      end
   endtask

   task automatic test_stop();
      bit to;
      int off;
      sel = 2'd3; rgb = 24'($urandom); enable = 1'b1;
      off = cur_off();
      run_frame(1'b0, 10, -1, 2'd0, to);
      mdl_frames++;
      n_tests++;
      if (to || beat_d.size() != NPIX) begin
         n_fail++;
         $display("FAIL stop_beats: got %0d want %0d", beat_d.size(), NPIX);
      end
      for (int k = 0; k < beat_d.size(); k++) begin
         n_tests++;
         if (beat_d[k] !== exp_pix(2'd3, rgb, k % H, k / H, off) || beat_l[k] !== (k == NPIX - 1)) begin
            n_fail++;
            $display("FAIL stop_pix%0d: got %h/%b want %h/%b", k, beat_d[k], beat_l[k],
                     exp_pix(2'd3, rgb, k % H, k / H, off), k == NPIX - 1);
         end
      end
      n_tests++;
      if (tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_tvalid: got %b want 0", tvalid);
      end
   endtask

   task automatic test_pattern_switch();
      bit to;
      int off;
      sel = 2'd1; enable = 1'b1;
      off = cur_off();
      run_frame(1'b0, -1, 3, 2'd2, to);
      mdl_frames++;
      for (int k = 0; k < beat_d.size(); k++) begin
         n_tests++;
         if (beat_d[k] !== exp_pix(2'd1, rgb, k % H, k / H, off)) begin
            n_fail++;
            $display("FAIL sw_grad%0d: got %h want %h", k, beat_d[k], exp_pix(2'd1, rgb, k % H, k / H, off));
         end
      end
`ifndef AXIS_PATTERN_SCROLL_EN
      n_tests++;
      if (beat_d.size() < 6 || beat_d[5] !== 32'h00050505) begin
         n_fail++;
         $display("FAIL sw_grad_x5: got %h want 00050505", beat_d.size() > 5 ? beat_d[5] : 32'hx);
      end
`endif
      off = cur_off();
      run_frame(1'b0, 1, -1, 2'd0, to);
      mdl_frames++;
      n_tests++;
      if (to || beat_d.size() != NPIX) begin
         n_fail++;
         $display("FAIL sw_chk_beats: got %0d want %0d", beat_d.size(), NPIX);
      end
      for (int k = 0; k < beat_d.size(); k++) begin
         n_tests++;
         if (beat_d[k] !== exp_pix(2'd2, rgb, k % H, k / H, off)) begin
            n_fail++;
            $display("FAIL sw_chk%0d: got %h want %h", k, beat_d[k], exp_pix(2'd2, rgb, k % H, k / H, off));
         end
      end
`ifndef AXIS_PATTERN_SCROLL_EN
      n_tests++;
      if (beat_d.size() < 9 || beat_d[8] !== 32'h00FFFFFF || beat_d[0] !== 32'h00000000) begin
         n_fail++;
         $display("FAIL sw_chk_spot: got %h %h want 00ffffff 00000000",
                  beat_d.size() > 8 ? beat_d[8] : 32'hx, beat_d.size() > 0 ? beat_d[0] : 32'hx);
      end
`endif
   endtask

   task automatic test_random_frames();
      bit to;
      int off;
      logic [1:0] cur_sel, nxt_sel;
      rgb = 24'($urandom);
      cur_sel = 2'($urandom);
      sel = cur_sel; enable = 1'b1;
      for (int f = 0; f < 3; f++) begin
         nxt_sel = 2'($urandom);
         off = cur_off();
         run_frame(1'b1, (f == 2) ? 2 : -1, 20, nxt_sel, to);
         mdl_frames++;
         n_tests++;
         if (to || beat_d.size() != NPIX || stab_err != 0) begin
            n_fail++;
            $display("FAIL rnd_frame%0d: got %0d beats unstable=%0d want %0d/0", f, beat_d.size(), stab_err, NPIX);
         end
         for (int k = 0; k < beat_d.size(); k++) begin
            n_tests++;
            if (beat_d[k] !== exp_pix(cur_sel, rgb, k % H, k / H, off) || beat_l[k] !== (k == NPIX - 1)) begin
               n_fail++;
               $display("FAIL rnd_f%0d_pix%0d: got %h/%b want %h/%b", f, k, beat_d[k], beat_l[k],
                        exp_pix(cur_sel, rgb, k % H, k / H, off), k == NPIX - 1);
            end
         end
         cur_sel = nxt_sel;
      end
      n_tests++;
      if (fc !== 8'(mdl_frames) || tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL rnd_end: got fc=%0d v=%b want %0d/0", fc, tvalid, mdl_frames);
      end
   endtask

   task automatic test_async_reset();
      bit to;
      int cnt;
      sel = 2'd0; enable = 1'b1; tready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 200 && cnt < 30; c++) begin
         if (tvalid) cnt++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (cnt != 30) begin
         n_fail++;
         $display("FAIL arst_reach: got %0d beats want 30", cnt);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (tvalid !== 1'b0 || tlast !== 1'b0 || tdata !== 32'h0 || fc !== 8'h0) begin
         n_fail++;
         $display("FAIL arst_async: got v=%b l=%b d=%h fc=%0d want 0/0/0/0", tvalid, tlast, tdata, fc);
      end
      mdl_frames = 0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_frame(1'b0, 1, -1, 2'd0, to);
      n_tests++;
      if (to || beat_d.size() != NPIX || beat_d[0] !== exp_pix(2'd0, rgb, 0, 0, 0)) begin
         n_fail++;
         $display("FAIL arst_restart: got %0d beats first=%h want %0d/%h", beat_d.size(),
                  beat_d.size() > 0 ? beat_d[0] : 32'hx, NPIX, exp_pix(2'd0, rgb, 0, 0, 0));
      end
      mdl_frames++;
      n_tests++;
      if (fc !== 8'd1) begin
         n_fail++;
         $display("FAIL arst_fc: got %0d want 1", fc);
      end
   endtask

`ifdef AXIS_PATTERN_SCROLL_EN
   task automatic test_scroll();
      bit to;
      sel = 2'd1; enable = 1'b1;
      run_frame(1'b0, -1, -1, 2'd0, to);
      mdl_frames++;
      n_tests++;
      if (to || beat_d.size() == 0 || beat_d[0] !== 32'h00010101) begin
         n_fail++;
         $display("FAIL scroll_f2: got %h want 00010101", beat_d.size() > 0 ? beat_d[0] : 32'hx);
      end
      run_frame(1'b0, 1, -1, 2'd0, to);
      mdl_frames++;
      n_tests++;
      if (to || beat_d.size() == 0 || beat_d[0] !== 32'h00020202) begin
         n_fail++;
         $display("FAIL scroll_f3: got %h want 00020202", beat_d.size() > 0 ? beat_d[0] : 32'hx);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_bars();
      test_backpressure();
      test_stop();
      test_pattern_switch();
      test_random_frames();
      test_async_reset();
`ifdef AXIS_PATTERN_SCROLL_EN
      test_scroll();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
